// File: rtl/heap_ctrl_if.sv
// ============================================================================
// Module      : heap_ctrl_if
// Description : Request/response handshake and RAM drive bundle for the
//               cons-cell heap controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface heap_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] req_data2;

    // Response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    // Allocator status
    logic [ADDR_WIDTH-1:0] free_ptr;

    // Attached single-port synchronous RAM
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requester / RAM side
    modport master (
        output req_valid, req_op, req_addr, req_data, req_data2,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  free_ptr, mem_we, mem_addr, mem_wdata
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_data2,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output free_ptr, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/heap_ctrl.sv
// ============================================================================
// Module      : heap_ctrl
// Description : Bump-pointer heap controller. Serves READ / WRITE of single
//               RAM words, CONS (allocate and fill a two-word cell) and CLEAR
//               (reset the allocator) over a valid/ready request and response
//               handshake, driving a synchronous RAM with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int HEAP_BASE  = 16,
    parameter int HEAP_LIMIT = 1023
) (
    input  wire logic   clk,
    input  wire logic   rst,
    heap_ctrl_if.slave  bus
);

    localparam logic [1:0] c_op_read  = 2'd0;
    localparam logic [1:0] c_op_write = 2'd1;
    localparam logic [1:0] c_op_cons  = 2'd2;
    localparam logic [1:0] c_op_clear = 2'd3;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_rd_issue = 3'd1;
    localparam logic [2:0] c_st_rd_capt  = 3'd2;
    localparam logic [2:0] c_st_wr       = 3'd3;
    localparam logic [2:0] c_st_cons_cdr = 3'd4;
    localparam logic [2:0] c_st_resp     = 3'd5;

    // The pointer is one bit wider than the address so that a heap filled
    // right up to the top of the address space reads as HEAP_LIMIT+1 rather
    // than wrapping back to a small address that would look free.
    localparam logic [ADDR_WIDTH:0] c_heap_base  = (ADDR_WIDTH+1)'(HEAP_BASE);
    localparam logic [ADDR_WIDTH:0] c_heap_limit = (ADDR_WIDTH+1)'(HEAP_LIMIT);
    localparam logic [ADDR_WIDTH:0] c_one        = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_two        = (ADDR_WIDTH+1)'(2);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_cons_full;
    logic [ADDR_WIDTH:0]   w_ptr_plus1;

    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data2;
    logic [ADDR_WIDTH:0]   r_free_ptr;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_data;

    assign w_ptr_plus1 = r_free_ptr + c_one;
    assign w_cons_full = (w_ptr_plus1 > c_heap_limit);
    assign w_accept    = bus.req_valid && w_req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        c_op_read:  w_state_next = c_st_rd_issue;
                        c_op_write: w_state_next = c_st_wr;
                        c_op_cons:  w_state_next = w_cons_full ? c_st_resp : c_st_cons_cdr;
                        default:    w_state_next = c_st_resp;
                    endcase
                end
            end
            c_st_rd_issue: w_state_next = c_st_rd_capt;
            c_st_rd_capt:  w_state_next = c_st_resp;
            c_st_cons_cdr: w_state_next = c_st_wr;
            c_st_wr:       w_state_next = c_st_resp;
            c_st_resp: begin
                if (bus.resp_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default:       w_state_next = c_st_idle;
        endcase
    end

    // Ready is offered only while idle and out of reset
    always_comb begin
        w_req_ready = 1'b0;
        if (!rst && (r_state == c_st_idle)) begin
            w_req_ready = 1'b1;
        end
    end

    // Request latch, allocator pointer, RAM drive and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= c_op_read;
            r_addr       <= '0;
            r_data2      <= '0;
            r_free_ptr   <= c_heap_base;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op    <= bus.req_op;
                        r_addr  <= bus.req_addr;
                        r_data2 <= bus.req_data2;
                        case (bus.req_op)
                            c_op_read: begin
                                r_mem_addr <= bus.req_addr;
                            end
                            c_op_write: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= bus.req_addr;
                                r_mem_wdata <= bus.req_data;
                            end
                            c_op_cons: begin
                                if (w_cons_full) begin
                                    r_resp_err   <= 1'b1;
                                    r_resp_valid <= 1'b1;
                                end else begin
                                    // car goes to the first word of the cell
                                    r_mem_we    <= 1'b1;
                                    r_mem_addr  <= r_free_ptr[ADDR_WIDTH-1:0];
                                    r_mem_wdata <= bus.req_data;
                                end
                            end
                            default: begin
                                r_free_ptr   <= c_heap_base;
                                r_resp_data  <= DATA_WIDTH'(c_heap_base);
                                r_resp_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                c_st_rd_capt: begin
                    r_resp_data  <= bus.mem_rdata;
                    r_resp_valid <= 1'b1;
                end
                c_st_cons_cdr: begin
                    // cdr goes to the second word; response is the cell base
                    r_mem_addr  <= w_ptr_plus1[ADDR_WIDTH-1:0];
                    r_mem_wdata <= r_data2;
                    r_resp_data <= DATA_WIDTH'(r_free_ptr);
                end
                c_st_wr: begin
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    if (r_op == c_op_cons) begin
                        r_free_ptr <= r_free_ptr + c_two;
                    end else begin
                        r_resp_data <= DATA_WIDTH'(r_addr);
                    end
                end
                c_st_resp: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_mem_we <= r_mem_we;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_data  = r_resp_data;
    assign bus.free_ptr   = r_free_ptr[ADDR_WIDTH-1:0];
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_heap_ctrl.sv
// ============================================================================
// Module      : tb_heap_ctrl
// Description : Directed self-checking bench for heap_ctrl with a small heap
//               (words 16..19) and a synchronous RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_heap_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    heap_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();

    heap_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .HEAP_BASE  (16),
        .HEAP_LIMIT (19)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    // Synchronous RAM: write and read on the same edge, read data next cycle
    logic [DW-1:0] ram [0:(1<<AW)-1];
    int            wr_count = 0;

    always @(posedge clk) begin
        if (hif.mem_we) begin
            ram[hif.mem_addr] <= hif.mem_wdata;
            wr_count          <= wr_count + 1;
        end
        hif.mem_rdata <= ram[hif.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle negedge; scramble the inputs right after
    // the accept edge and return the number of posedges to resp_valid.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] d2,
                         output int edges);
        hif.req_op    = op;
        hif.req_addr  = a;
        hif.req_data  = d;
        hif.req_data2 = d2;
        hif.req_valid = 1'b1;
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        hif.req_addr  = ~a;
        hif.req_data  = ~d;
        hif.req_data2 = ~d2;
        edges = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hif.resp_valid) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack();
        hif.resp_ready = 1'b1;
        @(negedge clk);
        hif.resp_ready = 1'b0;
        check("ack_valid_clr", 32'(hif.resp_valid), 32'd0);
        check("ack_err_clr",   32'(hif.resp_err),   32'd0);
        check("ack_ready",     32'(hif.req_ready),  32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(hif.req_ready),  32'd0);
        check("rst_resp_valid", 32'(hif.resp_valid), 32'd0);
        check("rst_free_ptr",   32'(hif.free_ptr),   32'd16);
        check("rst_mem_we",     32'(hif.mem_we),     32'd0);
        check("rst_mem_addr",   32'(hif.mem_addr),   32'd0);
        check("rst_resp_data",  hif.resp_data,       32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(hif.req_ready), 32'd1);
        @(negedge clk);
    endtask

    int edges;
    int wc0;

    initial begin
        rst           = 1'b1;
        hif.req_valid = 1'b0;
        hif.req_op    = 2'd0;
        hif.req_addr  = '0;
        hif.req_data  = '0;
        hif.req_data2 = '0;
        hif.resp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // WRITE 0x020 <= DEADBEEF; inputs are scrambled during WR
        issue(2'd1, 10'h020, 32'hDEADBEEF, 32'h0, edges);
        check("wr_latency",   32'(edges),        32'd1);
        check("wr_resp_data", hif.resp_data,     32'h20);
        check("wr_resp_err",  32'(hif.resp_err), 32'd0);
        check("wr_mem_we_off", 32'(hif.mem_we),  32'd0);
        ack();

        // READ 0x020, then hold the response for 5 cycles with a request pending
        issue(2'd0, 10'h020, 32'h0, 32'h0, edges);
        check("rd_latency",   32'(edges),    32'd2);
        check("rd_resp_data", hif.resp_data, 32'hDEADBEEF);
        hif.req_op    = 2'd1;
        hif.req_addr  = 10'h005;
        hif.req_data  = 32'h55;
        hif.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(hif.resp_valid), 32'd1);
            check("hold_data",  hif.resp_data,       32'hDEADBEEF);
            check("hold_ready", 32'(hif.req_ready),  32'd0);
        end
        ack();
        hif.req_valid = 1'b0;
        check("no_accept_on_release", 32'(hif.mem_we), 32'd0);

        // WRITE at the top address
        issue(2'd1, 10'h3FF, 32'hA5A55A5A, 32'h0, edges);
        check("wr_top_resp", hif.resp_data, 32'h3FF);
        ack();
        issue(2'd0, 10'h3FF, 32'h0, 32'h0, edges);
        check("rd_top_resp", hif.resp_data, 32'hA5A55A5A);
        ack();

        // Two CONS fill the whole heap
        do_reset();
        wc0 = wr_count;
        issue(2'd2, 10'h0, 32'h11, 32'h22, edges);
        check("cons1_latency", 32'(edges),         32'd2);
        check("cons1_base",    hif.resp_data,      32'd16);
        check("cons1_err",     32'(hif.resp_err),  32'd0);
        check("cons1_ptr",     32'(hif.free_ptr),  32'd18);
        ack();
        issue(2'd2, 10'h0, 32'h11, 32'h22, edges);
        check("cons2_base", hif.resp_data,     32'd18);
        check("cons2_ptr",  32'(hif.free_ptr), 32'd20);
        ack();
        check("ram16", ram[16], 32'h11);
        check("ram17", ram[17], 32'h22);
        check("ram18", ram[18], 32'h11);
        check("ram19", ram[19], 32'h22);
        check("cons_writes", 32'(wr_count - wc0), 32'd4);

        // Third CONS on a full heap
        wc0 = wr_count;
        issue(2'd2, 10'h0, 32'h33, 32'h44, edges);
        check("full_latency", 32'(edges),        32'd0);
        check("full_err",     32'(hif.resp_err), 32'd1);
        check("full_ptr",     32'(hif.free_ptr), 32'd20);
        ack();
        check("full_no_write", 32'(wr_count - wc0), 32'd0);

        // CLEAR
        issue(2'd3, 10'h0, 32'h0, 32'h0, edges);
        check("clr_latency", 32'(edges),        32'd0);
        check("clr_resp",    hif.resp_data,     32'd16);
        check("clr_ptr",     32'(hif.free_ptr), 32'd16);
        ack();

        // Reset while in CONS_CDR aborts the CONS
        hif.req_op    = 2'd2;
        hif.req_data  = 32'hAA;
        hif.req_data2 = 32'hBB;
        hif.req_valid = 1'b1;
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_we",  32'(hif.mem_we),     32'd0);
        check("abort_ptr",     32'(hif.free_ptr),   32'd16);
        check("abort_valid",   32'(hif.resp_valid), 32'd0);
        check("abort_car_ram", ram[16],             32'hAA);
        check("abort_ram17",   ram[17],             32'h22);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(hif.resp_valid), 32'd0);
        end
        issue(2'd3, 10'h0, 32'h0, 32'h0, edges);
        check("abort_clr_resp", hif.resp_data, 32'd16);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a wait outside the bounded loops never returns
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
